// File: rtl/rv32_decode_pkg.sv
// Shared RV32I(+M) decode definitions: opcodes, funct7 values, instruction IDs,
// the decoded-beat record and the immediate builder.
package rv32_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [5:0] {
    ID_ILLEGAL = 6'd0,
    ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND,
    ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI, ID_SLLI, ID_SRLI, ID_SRAI,
    ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
    ID_SB, ID_SH, ID_SW,
    ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
    ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
    ID_ECALL, ID_EBREAK,
    ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU, ID_DIV, ID_DIVU, ID_REM, ID_REMU
  } id_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    id_e         id;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
    logic [31:0] v;
    case (f)
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I(+M) decoder; any unmatched encoding yields ID_ILLEGAL
// with all usage flags and the immediate forced to zero.
module rv32_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  id_e        w_id;
  imm_fmt_e   w_fmt;
  logic       w_wr;
  logic       w_use1;
  logic       w_use2;
  logic       w_ill;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_rd  = i_instr[11:7];

  always_comb begin
    w_id   = ID_ILLEGAL;
    w_fmt  = IMM_NONE;
    w_wr   = 1'b0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_wr   = 1'b1;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'd0:    w_id = ID_ADD;
            3'd1:    w_id = ID_SLL;
            3'd2:    w_id = ID_SLT;
            3'd3:    w_id = ID_SLTU;
            3'd4:    w_id = ID_XOR;
            3'd5:    w_id = ID_SRL;
            3'd6:    w_id = ID_OR;
            default: w_id = ID_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            3'd0:    w_id = ID_SUB;
            3'd5:    w_id = ID_SRA;
            default: w_id = ID_ILLEGAL;
          endcase
        end else if (ENABLE_M && (w_f7 == F7_MULDIV)) begin
          case (w_f3)
            3'd0:    w_id = ID_MUL;
            3'd1:    w_id = ID_MULH;
            3'd2:    w_id = ID_MULHSU;
            3'd3:    w_id = ID_MULHU;
            3'd4:    w_id = ID_DIV;
            3'd5:    w_id = ID_DIVU;
            3'd6:    w_id = ID_REM;
            default: w_id = ID_REMU;
          endcase
        end
      end
      OPC_OP_IMM: begin
        w_wr   = 1'b1;
        w_use1 = 1'b1;
        w_fmt  = IMM_I;
        case (w_f3)
          3'd0: w_id = ID_ADDI;
          3'd2: w_id = ID_SLTI;
          3'd3: w_id = ID_SLTIU;
          3'd4: w_id = ID_XORI;
          3'd6: w_id = ID_ORI;
          3'd7: w_id = ID_ANDI;
          3'd1: w_id = (w_f7 == F7_BASE) ? ID_SLLI : ID_ILLEGAL;
          default: begin
            if (w_f7 == F7_BASE)     w_id = ID_SRLI;
            else if (w_f7 == F7_ALT) w_id = ID_SRAI;
          end
        endcase
      end
      OPC_LOAD: begin
        w_wr   = 1'b1;
        w_use1 = 1'b1;
        w_fmt  = IMM_I;
        case (w_f3)
          3'd0:    w_id = ID_LB;
          3'd1:    w_id = ID_LH;
          3'd2:    w_id = ID_LW;
          3'd4:    w_id = ID_LBU;
          3'd5:    w_id = ID_LHU;
          default: w_id = ID_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_fmt  = IMM_S;
        case (w_f3)
          3'd0:    w_id = ID_SB;
          3'd1:    w_id = ID_SH;
          3'd2:    w_id = ID_SW;
          default: w_id = ID_ILLEGAL;
        endcase
      end
      OPC_BRANCH: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_fmt  = IMM_B;
        case (w_f3)
          3'd0:    w_id = ID_BEQ;
          3'd1:    w_id = ID_BNE;
          3'd4:    w_id = ID_BLT;
          3'd5:    w_id = ID_BGE;
          3'd6:    w_id = ID_BLTU;
          3'd7:    w_id = ID_BGEU;
          default: w_id = ID_ILLEGAL;
        endcase
      end
      OPC_JAL: begin
        w_wr  = 1'b1;
        w_fmt = IMM_J;
        w_id  = ID_JAL;
      end
      OPC_JALR: begin
        w_wr   = 1'b1;
        w_use1 = 1'b1;
        w_fmt  = IMM_I;
        if (w_f3 == 3'd0) w_id = ID_JALR;
      end
      OPC_LUI: begin
        w_wr  = 1'b1;
        w_fmt = IMM_U;
        w_id  = ID_LUI;
      end
      OPC_AUIPC: begin
        w_wr  = 1'b1;
        w_fmt = IMM_U;
        w_id  = ID_AUIPC;
      end
      OPC_SYSTEM: begin
        // rd/rs1 fields are not qualified; only funct3 and imm[11:0] select the op
        w_fmt = IMM_I;
        if (w_f3 == 3'd0) begin
          if (i_instr[31:20] == 12'd0)      w_id = ID_ECALL;
          else if (i_instr[31:20] == 12'd1) w_id = ID_EBREAK;
        end
      end
      default: w_id = ID_ILLEGAL;
    endcase
  end

  assign w_ill = (w_id == ID_ILLEGAL);

  assign o_dec.id       = w_id;
  assign o_dec.rd       = w_rd;
  assign o_dec.rs1      = i_instr[19:15];
  assign o_dec.rs2      = i_instr[24:20];
  assign o_dec.imm      = w_ill ? 32'h0 : imm_gen(i_instr, w_fmt);
  assign o_dec.rd_we    = w_wr && !w_ill && (w_rd != 5'd0);
  assign o_dec.rs1_used = w_use1 && !w_ill;
  assign o_dec.rs2_used = w_use2 && !w_ill;
  assign o_dec.illegal  = w_ill;

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered decode stage: combinational decoder feeding an output register backed
// by a one-entry skid buffer so that in_ready can come straight from a flop.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int ID_W     = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [ID_W-1:0] o_out_id,
  output logic [4:0]      o_out_rd,
  output logic [4:0]      o_out_rs1,
  output logic [4:0]      o_out_rs2,
  output logic [31:0]     o_out_imm,
  output logic            o_out_rd_we,
  output logic            o_out_rs1_used,
  output logic            o_out_rs2_used,
  output logic            o_out_illegal
);

  dec_t            w_dec;
  logic            w_in_fire;
  logic            w_out_load;
  logic            w_skid_next;

  logic            r_in_ready;
  logic            r_out_valid;
  dec_t            r_out_dec;
  logic [XLEN-1:0] r_out_pc;
  logic            r_skid_valid;
  dec_t            r_skid_dec;
  logic [XLEN-1:0] r_skid_pc;

  rv32_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .i_instr (i_in_instr),
    .o_dec   (w_dec)
  );

  assign w_in_fire  = i_in_valid && r_in_ready;
  assign w_out_load = !r_out_valid || i_out_ready;
  // The skid only fills while the output is stalled; it empties on the next load.
  assign w_skid_next = r_skid_valid ? !w_out_load : (w_in_fire && !w_out_load);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_dec    <= '0;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_dec   <= '0;
      r_skid_pc    <= '0;
    end else if (i_flush) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_next;
      r_in_ready   <= !w_skid_next;
      if (w_out_load) begin
        if (r_skid_valid) begin
          r_out_dec   <= r_skid_dec;
          r_out_pc    <= r_skid_pc;
          r_out_valid <= 1'b1;
        end else if (w_in_fire) begin
          r_out_dec   <= w_dec;
          r_out_pc    <= i_in_pc;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_dec <= w_dec;
        r_skid_pc  <= i_in_pc;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_pc       = r_out_pc;
  assign o_out_id       = ID_W'(r_out_dec.id);
  assign o_out_rd       = r_out_dec.rd;
  assign o_out_rs1      = r_out_dec.rs1;
  assign o_out_rs2      = r_out_dec.rs2;
  assign o_out_imm      = r_out_dec.imm;
  assign o_out_rd_we    = r_out_dec.rd_we;
  assign o_out_rs1_used = r_out_dec.rs1_used;
  assign o_out_rs2_used = r_out_dec.rs2_used;
  assign o_out_illegal  = r_out_dec.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: two instances (M enabled / disabled) share stimulus and
// are checked against a mask/match instruction table and a queue-based handshake model.
module tb_rv32_decode_stage;
  import rv32_decode_pkg::*;

  localparam int FR = 0, FI = 1, FS = 2, FB = 3, FU = 4, FJ = 5, FY = 6;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  id;
    int          fmt;
    bit          m;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1u;
    logic        rs2u;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_rd_we, a_rs1u, a_rs2u, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [5:0]  a_id;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic        b_in_ready, b_out_valid, b_rd_we, b_rs1u, b_rs2u, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [5:0]  b_id;
  logic [4:0]  b_rd, b_rs1, b_rs2;

  ent_t        tbl[$];
  beat_t       q[$];
  logic        m_in_ready = 1'b0;
  bit          last_acc;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ID_W(6)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(a_in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_out_valid(a_out_valid), .i_out_ready(out_ready),
    .o_out_pc(a_pc), .o_out_id(a_id), .o_out_rd(a_rd), .o_out_rs1(a_rs1), .o_out_rs2(a_rs2),
    .o_out_imm(a_imm), .o_out_rd_we(a_rd_we), .o_out_rs1_used(a_rs1u),
    .o_out_rs2_used(a_rs2u), .o_out_illegal(a_ill)
  );

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ID_W(6)) dut_nom (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_out_valid(b_out_valid), .i_out_ready(out_ready),
    .o_out_pc(b_pc), .o_out_id(b_id), .o_out_rd(b_rd), .o_out_rs1(b_rs1), .o_out_rs2(b_rs2),
    .o_out_imm(b_imm), .o_out_rd_we(b_rd_we), .o_out_rs1_used(b_rs1u),
    .o_out_rs2_used(b_rs2u), .o_out_illegal(b_ill)
  );

  function automatic void add(id_e id, int fmt, logic [6:0] opc, int f3, int f7,
                              int imm12 = -1, bit m = 1'b0);
    ent_t e;
    e.mask  = 32'h7F;
    e.match = {25'd0, opc};
    if (f3 >= 0)    begin e.mask |= 32'h0000_7000; e.match |= (32'(f3) << 12); end
    if (f7 >= 0)    begin e.mask |= 32'hFE00_0000; e.match |= (32'(f7) << 25); end
    if (imm12 >= 0) begin e.mask |= 32'hFFF0_0000; e.match |= (32'(imm12) << 20); end
    e.id  = id;
    e.fmt = fmt;
    e.m   = m;
    tbl.push_back(e);
  endfunction

  function automatic void build_table();
    add(ID_ADD, FR, 7'h33, 0, 0);     add(ID_SUB, FR, 7'h33, 0, 32);
    add(ID_SLL, FR, 7'h33, 1, 0);     add(ID_SLT, FR, 7'h33, 2, 0);
    add(ID_SLTU, FR, 7'h33, 3, 0);    add(ID_XOR, FR, 7'h33, 4, 0);
    add(ID_SRL, FR, 7'h33, 5, 0);     add(ID_SRA, FR, 7'h33, 5, 32);
    add(ID_OR, FR, 7'h33, 6, 0);      add(ID_AND, FR, 7'h33, 7, 0);
    add(ID_ADDI, FI, 7'h13, 0, -1);   add(ID_SLTI, FI, 7'h13, 2, -1);
    add(ID_SLTIU, FI, 7'h13, 3, -1);  add(ID_XORI, FI, 7'h13, 4, -1);
    add(ID_ORI, FI, 7'h13, 6, -1);    add(ID_ANDI, FI, 7'h13, 7, -1);
    add(ID_SLLI, FI, 7'h13, 1, 0);    add(ID_SRLI, FI, 7'h13, 5, 0);
    add(ID_SRAI, FI, 7'h13, 5, 32);
    add(ID_LB, FI, 7'h03, 0, -1);     add(ID_LH, FI, 7'h03, 1, -1);
    add(ID_LW, FI, 7'h03, 2, -1);     add(ID_LBU, FI, 7'h03, 4, -1);
    add(ID_LHU, FI, 7'h03, 5, -1);
    add(ID_SB, FS, 7'h23, 0, -1);     add(ID_SH, FS, 7'h23, 1, -1);
    add(ID_SW, FS, 7'h23, 2, -1);
    add(ID_BEQ, FB, 7'h63, 0, -1);    add(ID_BNE, FB, 7'h63, 1, -1);
    add(ID_BLT, FB, 7'h63, 4, -1);    add(ID_BGE, FB, 7'h63, 5, -1);
    add(ID_BLTU, FB, 7'h63, 6, -1);   add(ID_BGEU, FB, 7'h63, 7, -1);
    add(ID_LUI, FU, 7'h37, -1, -1);   add(ID_AUIPC, FU, 7'h17, -1, -1);
    add(ID_JAL, FJ, 7'h6F, -1, -1);   add(ID_JALR, FI, 7'h67, 0, -1);
    add(ID_ECALL, FY, 7'h73, 0, -1, 0); add(ID_EBREAK, FY, 7'h73, 0, -1, 1);
    for (int f = 0; f < 8; f++) add(id_e'(6'(int'(ID_MUL) + f)), FR, 7'h33, f, 1, -1, 1'b1);
  endfunction

  function automatic exp_t ref_dec(logic [31:0] i, bit en_m);
    exp_t e;
    int   fmt = -1;
    e = '0;
    foreach (tbl[k])
      if (((i & tbl[k].mask) == tbl[k].match) && (!tbl[k].m || en_m)) begin
        fmt  = tbl[k].fmt;
        e.id = tbl[k].id;
      end
    if (fmt < 0) begin
      e.ill = 1'b1;
      return e;
    end
    case (fmt)
      FI, FY:  e.imm = 32'($signed(i[31:20]));
      FS:      e.imm = 32'($signed({i[31:25], i[11:7]}));
      FB:      e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      FU:      e.imm = i & 32'hFFFF_F000;
      FJ:      e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      default: e.imm = 32'h0;
    endcase
    e.rs1u  = (fmt == FR) || (fmt == FI) || (fmt == FS) || (fmt == FB);
    e.rs2u  = (fmt == FR) || (fmt == FS) || (fmt == FB);
    e.rd_we = ((fmt == FR) || (fmt == FI) || (fmt == FU) || (fmt == FJ)) && (i[11:7] != 5'd0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string t, bit en_m, logic rdy, logic vld, logic [31:0] pc,
                           logic [5:0] id, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                           logic [31:0] imm, logic we, logic u1, logic u2, logic ill);
    exp_t e;
    chk({t, "_in_ready"}, 32'(rdy), 32'(m_in_ready));
    chk({t, "_out_valid"}, 32'(vld), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = ref_dec(q[0].instr, en_m);
      chk({t, "_pc"}, pc, q[0].pc);
      chk({t, "_id"}, 32'(id), 32'(e.id));
      chk({t, "_rd"}, 32'(rd), 32'(q[0].instr[11:7]));
      chk({t, "_rs1"}, 32'(rs1), 32'(q[0].instr[19:15]));
      chk({t, "_rs2"}, 32'(rs2), 32'(q[0].instr[24:20]));
      chk({t, "_imm"}, imm, e.imm);
      chk({t, "_rd_we"}, 32'(we), 32'(e.rd_we));
      chk({t, "_rs1_used"}, 32'(u1), 32'(e.rs1u));
      chk({t, "_rs2_used"}, 32'(u2), 32'(e.rs2u));
      chk({t, "_illegal"}, 32'(ill), 32'(e.ill));
    end
  endtask

  // Drive one cycle, advance the reference model at the edge, then check both instances.
  task automatic step(bit v, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl, bit rs);
    beat_t b;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    last_acc = v && m_in_ready && !fl && !rs;
    if (rs || fl) q.delete();
    else begin
      if ((q.size() > 0) && ordy) void'(q.pop_front());
      if (last_acc) begin
        b.instr = ins;
        b.pc    = pc;
        q.push_back(b);
      end
    end
    m_in_ready = rs ? 1'b0 : (q.size() < 2);
    #1;
    check_dut("m", 1'b1, a_in_ready, a_out_valid, a_pc, a_id, a_rd, a_rs1, a_rs2, a_imm,
              a_rd_we, a_rs1u, a_rs2u, a_ill);
    check_dut("nom", 1'b0, b_in_ready, b_out_valid, b_pc, b_id, b_rd, b_rs1, b_rs2, b_imm,
              b_rd_we, b_rs1u, b_rs2u, b_ill);
    if (rs) begin
      chk("rst_id", 32'(a_id), 32'd0);
      chk("rst_pc", a_pc, 32'd0);
      chk("rst_imm", a_imm, 32'd0);
      chk("rst_fields", {17'd0, a_rd, a_rs1, a_rs2, a_rd_we, a_rs1u, a_rs2u, a_ill}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    ent_t e;
    if ($urandom_range(0, 9) < 8) begin
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      return e.match | ($urandom & ~e.mask);
    end
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seen[$];
    logic [31:0] pc_n;
    int          idx;

    build_table();

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_in_ready", 32'(a_in_ready), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_in_ready", 32'(a_in_ready), 32'd1);

    // addi x1,x2,5
    step(1'b1, 32'h0051_0093, 32'h1000, 1'b1, 1'b0, 1'b0);
    chk("addi_id", 32'(a_id), 32'(ID_ADDI));
    chk("addi_imm", a_imm, 32'h5);
    chk("addi_rd_we", 32'(a_rd_we), 32'd1);
    chk("addi_rs2_used", 32'(a_rs2u), 32'd0);

    step(1'b1, 32'h1234_52B7, 32'h1004, 1'b1, 1'b0, 1'b0);
    chk("lui_id", 32'(a_id), 32'(ID_LUI));
    chk("lui_rd", 32'(a_rd), 32'd5);
    chk("lui_imm", a_imm, 32'h1234_5000);

    step(1'b1, 32'hFE00_0EE3, 32'h1008, 1'b1, 1'b0, 1'b0);
    chk("beq_id", 32'(a_id), 32'(ID_BEQ));
    chk("beq_imm", a_imm, 32'hFFFF_FFFC);
    chk("beq_flags", {29'd0, a_rd_we, a_rs1u, a_rs2u}, 32'd3);

    step(1'b1, 32'h0220_81B3, 32'h100C, 1'b1, 1'b0, 1'b0);
    chk("mul_id_m", 32'(a_id), 32'(ID_MUL));
    chk("mul_illegal_nom", 32'(b_ill), 32'd1);
    chk("mul_id_nom", 32'(b_id), 32'd0);

    step(1'b1, 32'h0010_0073, 32'h1010, 1'b1, 1'b0, 1'b0);
    chk("ebreak_id", 32'(a_id), 32'(ID_EBREAK));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: stream PCs 0,4,8 with the output stalled for four cycles.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 32'h0000_0013 | (32'(idx) << 20), 32'(idx * 4), 1'b0, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (a_out_valid) seen.push_back(a_pc);
      step(idx < 3, 32'h0000_0013 | (32'(idx) << 20), 32'(idx * 4), 1'b1, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_count", 32'(seen.size()), 32'd3);
    for (int k = 0; k < seen.size(); k++) chk("bp_order", seen[k], 32'(k * 4));

    // Flush with output and skid both full.
    step(1'b1, 32'h0000_0033, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 32'h104, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_in_ready", 32'(a_in_ready), 32'd0);
    step(1'b1, 32'h0000_0033, 32'h108, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd1);
    // Flush while in_ready=1: the presented beat must still be dropped.
    step(1'b1, 32'h0000_0033, 32'h10C, 1'b1, 1'b1, 1'b0);
    chk("flush_drop_out_valid", 32'(a_out_valid), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_nothing_left", 32'(a_out_valid), 32'd0);

    // Reset mid-stream with the output stalled.
    step(1'b1, 32'h0051_0093, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0051_0093, 32'h204, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0051_0093, 32'h208, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_mid_out_id", 32'(a_id), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_release_in_ready", 32'(a_in_ready), 32'd1);

    // Randomized traffic against the reference model.
    pc_n = 32'h8000_0000;
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), pc_n, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0);
      if (last_acc) pc_n += 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
Registered RV32I(+M) instruction decode stage that sits between fetch and execute in the pipeline. It accepts {instr, pc} beats over a valid/ready handshake. It decodes each beat into register indices, a sign-extended immediate, a compact instruction ID and an illegal flag. Results are presented one cycle later through an output register backed by a one-entry skid buffer, which keeps in_ready registered. The stage supports pipeline flush, and the M extension can be enabled or disabled at build time.

Parameters:
XLEN, 32, width of the PC field carried alongside the instruction
ENABLE_M, 1, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = treat them as illegal
ID_W, 6, width of the instruction ID; must hold every ID in the shared package

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drops all buffered and output beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat; registered
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded beat valid
out_ready  in  1  downstream accepts the beat
out_pc  out  XLEN  PC of the decoded beat
out_id  out  ID_W  instruction ID (package enum; ID_ILLEGAL = 0)
out_rd  out  5  instr[11:7]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_imm  out  32  sign-extended immediate for I/S/B/U/J; 0 for R-type
out_rd_we  out  1  instruction writes rd and rd != 0
out_rs1_used  out  1  rs1 is a true source
out_rs2_used  out  1  rs2 is a true source
out_illegal  out  1  unknown opcode/funct combination, or M op with ENABLE_M=0

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, skid empty, all out_* data registers 0.
  - in_ready=0 during rst; in_ready=1 on the first cycle after rst deasserts.
- Handshakes:
  - A beat transfers in when in_valid && in_ready; it transfers out when out_valid && out_ready.
  - in_ready = !skid_valid, registered.
- Latency and load rules:
  - Latency is 1 cycle, from an accepted input to out_valid, when the output register is free.
  - The output register loads when !out_valid || out_ready.
  - Load source: the skid entry if one is held, otherwise the decoded input.
  - An input accepted while the output register is stalled (out_valid && !out_ready) goes to the skid, and in_ready drops on the next cycle.
  - When the output drains and the skid is occupied, the skid moves to the output and in_ready returns to 1 on the following cycle.
- Ordering and stability:
  - Beats leave in strict acceptance order.
  - No beat is lost or duplicated under any valid/ready pattern.
  - out_* fields hold stable while out_valid && !out_ready.
- Flush:
  - Synchronous. Clears out_valid and the skid at the edge.
  - Any input presented in the flush cycle is dropped, even if in_ready=1.
  - flush has priority over accept and over load.
  - flush and rst together behave as rst.
- Decode is fully combinational ahead of the register. It covers these opcodes:
  - 0110011 (R: ALU, plus M when funct7=0000001)
  - 0010011 (I-ALU; SLLI/SRLI require funct7=0, SRAI requires funct7=0100000)
  - 0000011 (loads, funct3 in {0,1,2,4,5})
  - 0100011 (stores, funct3 in {0,1,2})
  - 1100011 (branches, funct3 not in {2,3})
  - 1101111 JAL
  - 1100111 JALR (funct3=0)
  - 0110111 LUI
  - 0010111 AUIPC
  - 1110011 with funct3=0: ECALL if imm=0, EBREAK if imm=1
- Immediates:
  - I: {{20{i[31]}}, i[31:20]}
  - S: {{20{i[31]}}, i[31:25], i[11:7]}
  - B: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}
  - U: {i[31:12], 12'b0}
  - J: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}
- Source/destination usage:
  - rs1_used: R, I, S, B, JALR (not ECALL/EBREAK).
  - rs2_used: R, S, B.
  - rd_we: R, I-ALU, load, JAL, JALR, LUI, AUIPC, and only when rd != 0.
- Illegal beats:
  - out_illegal=1, out_id=ID_ILLEGAL, rd_we=0, rs1_used=0, rs2_used=0, imm=0.
  - The beat still flows through the handshake.

Decomposition:
- Package rv32_decode_pkg holds:
  - opcode localparams;
  - the instruction ID enum (ID_ILLEGAL=0, then ADD..REMU, 48 entries in total, fitting ID_W=6);
  - funct7 constants F7_BASE=0x00, F7_ALT=0x20, F7_MULDIV=0x01.
- Sub-module rv32_decode_comb (purely combinational, parameter ENABLE_M): instr -> {id, rd, rs1, rs2, imm, rd_we, rs1_used, rs2_used, illegal}.
- The stage module wraps the sub-module with the skid buffer and output register.

Test Plan:
- Single beat, out_ready=1: in_instr=0x00510093 (addi x1,x2,5) -> one cycle later out_id=ADDI, rd=1, rs1=2, imm=0x00000005, rd_we=1, rs2_used=0.
- LUI and branch immediates:
  - 0x123452B7 -> LUI, rd=5, imm=0x12345000;
  - 0xFE000EE3 -> BEQ, imm=0xFFFFFFFC, rd_we=0, rs1_used=1, rs2_used=1.
- M gating: 0x022081B3 (mul x3,x1,x2) -> with ENABLE_M=1, out_id=MUL; with ENABLE_M=0, out_illegal=1 and out_id=0.
- Backpressure:
  - stimulus: out_ready=0 for 4 cycles while in_valid=1 streams PCs 0x0,0x4,0x8;
  - required: in_ready drops after 2 beats are accepted;
  - then with out_ready=1: outputs 0x0, 0x4, 0x8 in order, nothing dropped or duplicated.
- Flush: output register and skid both full, flush=1 together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
- Reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_id=0; in_ready=1 the cycle after rst deasserts.
